rggen_register_common: RTL and testbench

RGGEN_REGISTER_COMMON -- requirements
Module: rggen_register_common

---
 rtl/rggen_register_common_if.sv | 31 +++
 rtl/rggen_register_common.sv | 145 ++++++++++++++
 tb/tb_rggen_register_common.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rggen_register_common_if.sv
// Register bus bundle between the register-block decoder (master) and one register (slave).
interface rggen_register_common_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32,
    parameter int DATA_WIDTH    = BUS_WIDTH
);
    logic                     register_valid;
    logic [1:0]               register_access;
    logic [ADDRESS_WIDTH-1:0] register_address;
    logic [BUS_WIDTH-1:0]     register_write_data;
    logic [BUS_WIDTH/8-1:0]   register_strobe;
    logic                     register_active;
    logic                     register_ready;
    logic [1:0]               register_status;
    logic [BUS_WIDTH-1:0]     register_read_data;
    logic [DATA_WIDTH-1:0]    register_value;

    modport master (
        output register_valid, register_access, register_address,
               register_write_data, register_strobe,
        input  register_active, register_ready, register_status,
               register_read_data, register_value
    );

    modport slave (
        input  register_valid, register_access, register_address,
               register_write_data, register_strobe,
        output register_active, register_ready, register_status,
               register_read_data, register_value
    );
endinterface

// File: rtl/rggen_register_common.sv
// Common register front end: address decode, lane select and bit-field mask generation.
// Optional RGGEN_BACKDOOR_EN adds a pending backdoor port that uses idle bus cycles.
module rggen_register_common #(
    parameter bit                    READABLE       = 1'b1,
    parameter bit                    WRITABLE       = 1'b1,
    parameter int                    ADDRESS_WIDTH  = 8,
    parameter int                    OFFSET_ADDRESS = 0,
    parameter int                    BUS_WIDTH      = 32,
    parameter int                    DATA_WIDTH     = BUS_WIDTH,
    parameter logic [DATA_WIDTH-1:0] VALID_BITS     = '1,
    parameter int                    REGISTER_INDEX = 0
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rggen_register_common_if.slave register_if,
    input  logic                  i_additional_match,
    output logic                  o_bit_field_valid,
    output logic [DATA_WIDTH-1:0] o_bit_field_read_mask,
    output logic [DATA_WIDTH-1:0] o_bit_field_write_mask,
    output logic [DATA_WIDTH-1:0] o_bit_field_write_data,
    input  logic [DATA_WIDTH-1:0] i_bit_field_read_data,
    input  logic [DATA_WIDTH-1:0] i_bit_field_value
`ifdef RGGEN_BACKDOOR_EN
    ,
    input  logic                  i_backdoor_valid,
    input  logic [DATA_WIDTH-1:0] i_backdoor_read_mask,
    input  logic [DATA_WIDTH-1:0] i_backdoor_write_mask,
    input  logic [DATA_WIDTH-1:0] i_backdoor_write_data,
    output logic                  o_backdoor_ready,
    output logic [DATA_WIDTH-1:0] o_backdoor_read_data
`endif
);
    localparam int unsigned BUS_BYTES  = BUS_WIDTH / 8;
    localparam int unsigned BYTE_SHIFT = $clog2(BUS_BYTES);
    localparam int unsigned WORDS      = DATA_WIDTH / BUS_WIDTH;
    localparam logic [63:0] BASE       = 64'(OFFSET_ADDRESS) + 64'(REGISTER_INDEX) * 64'(DATA_WIDTH / 8);

    logic [63:0]           address;
    logic [63:0]           word_offset;
    logic                  in_range;
    logic                  write;
    logic                  hit;
    logic                  bus_valid_hit;
    logic [BUS_WIDTH-1:0]  strobe_bits;
    logic [DATA_WIDTH-1:0] bus_read_mask;
    logic [DATA_WIDTH-1:0] bus_write_mask;
    logic [DATA_WIDTH-1:0] bus_write_data;
    logic [BUS_WIDTH-1:0]  bus_read_data;

    // Compare in bus-word units so the byte-offset bits never affect the hit.
    assign address     = 64'(register_if.register_address);
    assign word_offset = (address >> BYTE_SHIFT) - (BASE >> BYTE_SHIFT);
    assign in_range    = ((address >> BYTE_SHIFT) >= (BASE >> BYTE_SHIFT)) && (word_offset < 64'(WORDS));
    assign write       = register_if.register_access[0];
    assign hit         = in_range && i_additional_match && (write ? WRITABLE : READABLE);
    assign bus_valid_hit = register_if.register_valid && hit;

    always_comb begin
        strobe_bits = '0;
        for (int unsigned b = 0; b < BUS_WIDTH; b++) begin
            strobe_bits[b] = register_if.register_strobe[b/8];
        end
    end

    always_comb begin
        bus_read_mask  = '0;
        bus_write_mask = '0;
        bus_write_data = '0;
        bus_read_data  = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (bus_valid_hit && (word_offset == 64'(i))) begin
                if (write) begin
                    bus_write_mask[i*BUS_WIDTH +: BUS_WIDTH] = strobe_bits & VALID_BITS[i*BUS_WIDTH +: BUS_WIDTH];
                    bus_write_data[i*BUS_WIDTH +: BUS_WIDTH] = register_if.register_write_data;
                end else begin
                    bus_read_mask[i*BUS_WIDTH +: BUS_WIDTH] = VALID_BITS[i*BUS_WIDTH +: BUS_WIDTH];
                    bus_read_data = i_bit_field_read_data[i*BUS_WIDTH +: BUS_WIDTH] & VALID_BITS[i*BUS_WIDTH +: BUS_WIDTH];
                end
            end
        end
    end

    assign register_if.register_active    = hit;
    assign register_if.register_ready     = bus_valid_hit;
    assign register_if.register_status    = 2'b00;
    assign register_if.register_read_data = bus_read_data;
    assign register_if.register_value     = i_bit_field_value & VALID_BITS;

`ifdef RGGEN_BACKDOOR_EN
    typedef enum logic {BD_IDLE, BD_PENDING} bd_state_e;

    bd_state_e             bd_state;
    bd_state_e             bd_state_next;
    logic                  bd_apply;
    logic [DATA_WIDTH-1:0] bd_read_mask;
    logic [DATA_WIDTH-1:0] bd_write_mask;
    logic [DATA_WIDTH-1:0] bd_write_data;
    logic                  unused_access;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bd_state      <= BD_IDLE;
            bd_read_mask  <= '0;
            bd_write_mask <= '0;
            bd_write_data <= '0;
        end else begin
            bd_state <= bd_state_next;
            if (i_backdoor_valid) begin
                bd_read_mask  <= i_backdoor_read_mask;
                bd_write_mask <= i_backdoor_write_mask;
                bd_write_data <= i_backdoor_write_data;
            end
        end
    end

    // A bus hit wins the bit-field port; the backdoor waits for the next free cycle.
    always_comb begin
        bd_state_next = bd_state;
        bd_apply      = 1'b0;
        if ((bd_state == BD_PENDING) && !bus_valid_hit) begin
            bd_apply      = 1'b1;
            bd_state_next = BD_IDLE;
        end
        if (i_backdoor_valid) begin
            bd_state_next = BD_PENDING;
        end
    end

    assign o_bit_field_valid      = bus_valid_hit || bd_apply;
    assign o_bit_field_read_mask  = bd_apply ? bd_read_mask  : bus_read_mask;
    assign o_bit_field_write_mask = bd_apply ? bd_write_mask : bus_write_mask;
    assign o_bit_field_write_data = bd_apply ? bd_write_data : bus_write_data;
    assign o_backdoor_ready       = bd_apply;
    assign o_backdoor_read_data   = bd_apply ? i_bit_field_read_data : '0;
    assign unused_access          = register_if.register_access[1];
`else
    logic unused_inputs;

    assign o_bit_field_valid      = bus_valid_hit;
    assign o_bit_field_read_mask  = bus_read_mask;
    assign o_bit_field_write_mask = bus_write_mask;
    assign o_bit_field_write_data = bus_write_data;
    assign unused_inputs          = &{1'b0, i_clk, i_rst_n, register_if.register_access[1]};
`endif
endmodule

// File: tb/tb_rggen_register_common.sv
// Scoreboard bench for rggen_register_common: a writable and a write-protected instance at 0x10.
module tb_rggen_register_common;
    localparam logic [63:0] VB = 64'h0000_00FF_FFFF_00FF;

    typedef struct packed {
        logic        active;
        logic        ready;
        logic [1:0]  status;
        logic [31:0] read_data;
        logic [63:0] value;
        logic        bf_valid;
        logic [63:0] rmask;
        logic [63:0] wmask;
        logic [63:0] wdata;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        match;
    logic [63:0] bf_rd;
    logic [63:0] bf_val;

    logic        bf0_valid, bf1_valid;
    logic [63:0] bf0_rmask, bf0_wmask, bf0_wdata;
    logic [63:0] bf1_rmask, bf1_wmask, bf1_wdata;

    obs_t        sb[$];
    int unsigned tests_run = 0;
    int unsigned failures  = 0;

    always #5 clk = ~clk;

    rggen_register_common_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .DATA_WIDTH(64)) bus0 ();
    rggen_register_common_if #(.ADDRESS_WIDTH(8), .BUS_WIDTH(32), .DATA_WIDTH(64)) bus1 ();

`ifdef RGGEN_BACKDOOR_EN
    logic        bd_valid;
    logic [63:0] bd_rmask, bd_wmask, bd_wdata;
    logic        bd0_ready, bd1_ready;
    logic [63:0] bd0_rdata, bd1_rdata;
`endif

    rggen_register_common #(
        .READABLE(1'b1), .WRITABLE(1'b1), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(16),
        .BUS_WIDTH(32), .DATA_WIDTH(64), .VALID_BITS(VB), .REGISTER_INDEX(0)
    ) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .register_if(bus0), .i_additional_match(match),
        .o_bit_field_valid(bf0_valid), .o_bit_field_read_mask(bf0_rmask),
        .o_bit_field_write_mask(bf0_wmask), .o_bit_field_write_data(bf0_wdata),
        .i_bit_field_read_data(bf_rd), .i_bit_field_value(bf_val)
`ifdef RGGEN_BACKDOOR_EN
        , .i_backdoor_valid(bd_valid), .i_backdoor_read_mask(bd_rmask),
        .i_backdoor_write_mask(bd_wmask), .i_backdoor_write_data(bd_wdata),
        .o_backdoor_ready(bd0_ready), .o_backdoor_read_data(bd0_rdata)
`endif
    );

    rggen_register_common #(
        .READABLE(1'b1), .WRITABLE(1'b0), .ADDRESS_WIDTH(8), .OFFSET_ADDRESS(16),
        .BUS_WIDTH(32), .DATA_WIDTH(64), .VALID_BITS(VB), .REGISTER_INDEX(0)
    ) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .register_if(bus1), .i_additional_match(match),
        .o_bit_field_valid(bf1_valid), .o_bit_field_read_mask(bf1_rmask),
        .o_bit_field_write_mask(bf1_wmask), .o_bit_field_write_data(bf1_wdata),
        .i_bit_field_read_data(bf_rd), .i_bit_field_value(bf_val)
`ifdef RGGEN_BACKDOOR_EN
        , .i_backdoor_valid(1'b0), .i_backdoor_read_mask(64'h0),
        .i_backdoor_write_mask(64'h0), .i_backdoor_write_data(64'h0),
        .o_backdoor_ready(bd1_ready), .o_backdoor_read_data(bd1_rdata)
`endif
    );

    function automatic obs_t sample(input bit which);
        obs_t o;
        if (!which) begin
            o.active = bus0.register_active;  o.ready = bus0.register_ready;
            o.status = bus0.register_status;  o.read_data = bus0.register_read_data;
            o.value = bus0.register_value;    o.bf_valid = bf0_valid;
            o.rmask = bf0_rmask; o.wmask = bf0_wmask; o.wdata = bf0_wdata;
        end else begin
            o.active = bus1.register_active;  o.ready = bus1.register_ready;
            o.status = bus1.register_status;  o.read_data = bus1.register_read_data;
            o.value = bus1.register_value;    o.bf_valid = bf1_valid;
            o.rmask = bf1_rmask; o.wmask = bf1_wmask; o.wdata = bf1_wdata;
        end
        return o;
    endfunction

    // Reference: register occupies bytes 0x10..0x17, two 32-bit lanes.
    function automatic obs_t model(input bit writable, input logic valid, input logic [1:0] access,
                                   input logic [7:0] addr, input logic [31:0] wd, input logic [3:0] strb);
        obs_t        e;
        int unsigned a;
        int unsigned lane;
        bit          hit;
        e    = '0;
        a    = addr;
        hit  = (a >= 16) && (a < 24) && (match === 1'b1) && (!access[0] || writable);
        e.active = hit;
        e.value  = bf_val & VB;
        if (valid && hit) begin
            lane = (a - 16) / 4;
            e.ready = 1'b1;
            e.bf_valid = 1'b1;
            if (access[0]) begin
                for (int j = 0; j < 4; j++)
                    if (strb[j]) e.wmask[lane*32 + j*8 +: 8] = VB[lane*32 + j*8 +: 8];
                e.wdata[lane*32 +: 32] = wd;
            end else begin
                e.rmask[lane*32 +: 32] = VB[lane*32 +: 32];
                e.read_data = bf_rd[lane*32 +: 32] & VB[lane*32 +: 32];
            end
        end
        return e;
    endfunction

    task automatic drive(input logic valid, input logic [1:0] access, input logic [7:0] addr,
                         input logic [31:0] wd, input logic [3:0] strb);
        bus0.register_valid = valid; bus0.register_access = access; bus0.register_address = addr;
        bus0.register_write_data = wd; bus0.register_strobe = strb;
        bus1.register_valid = valid; bus1.register_access = access; bus1.register_address = addr;
        bus1.register_write_data = wd; bus1.register_strobe = strb;
    endtask

    task automatic test_reset();
        obs_t e, o;
        rst_n = 1'b0;
        match = 1'b1;
        bf_rd = 64'h0;
        bf_val = 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef RGGEN_BACKDOOR_EN
        bd_valid = 1'b0; bd_rmask = '0; bd_wmask = '0; bd_wdata = '0;
`endif
        drive(1'b0, 2'b00, 8'h80, 32'h0, 4'h0);
        e = '0;
        e.value = VB;
        sb.push_back(e);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL reset_idle: got %h expected %h", o, e); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_read();
        obs_t e, o;
        bf_rd  = 64'h1234_5678_9ABC_DEF0;
        bf_val = 64'h0123_4567_89AB_CDEF;
        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.read_data = 32'h0000_0078; e.rmask = 64'h0000_00FF_0000_0000; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b00, 8'h14, 32'h0, 4'h0);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL read_upper_lane: got %h expected %h", o, e); end

        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.read_data = 32'h9ABC_00F0; e.rmask = 64'h0000_0000_FFFF_00FF; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b10, 8'h10, 32'h0, 4'h0);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL read_lower_lane: got %h expected %h", o, e); end

        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.read_data = 32'h0000_0078; e.rmask = 64'h0000_00FF_0000_0000; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b00, 8'h17, 32'h0, 4'h0);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL read_unaligned: got %h expected %h", o, e); end
    endtask

    task automatic test_write();
        obs_t e, o;
        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.wmask = 64'h0000_0000_0000_00FF; e.wdata = 64'h0000_0000_AABB_CCDD; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b01, 8'h10, 32'hAABB_CCDD, 4'b0011);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL write_low_strobe: got %h expected %h", o, e); end

        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.wmask = 64'h0000_00FF_0000_0000; e.wdata = 64'h1122_3344_0000_0000; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b11, 8'h14, 32'h1122_3344, 4'b1111);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL write_upper_lane: got %h expected %h", o, e); end

        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.wmask = 64'h0000_0000_FFFF_0000; e.wdata = 64'h0000_0000_DEAD_BEEF; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b01, 8'h12, 32'hDEAD_BEEF, 4'b1100);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL write_high_strobe: got %h expected %h", o, e); end
    endtask

    task automatic test_miss();
        obs_t e, o;
        logic [7:0] addrs[3] = '{8'h18, 8'h0F, 8'h14};
        for (int i = 0; i < 3; i++) begin
            match = (i == 2) ? 1'b0 : 1'b1;
            e = '0; e.value = 64'h0000_0067_89AB_00EF;
            sb.push_back(e);
            drive(1'b1, 2'b00, addrs[i], 32'h0, 4'h0);
            #1;
            o = sample(0); e = sb.pop_front(); tests_run++;
            if (o !== e) begin failures++; $display("FAIL miss_%0d: got %h expected %h", i, o, e); end
        end
        match = 1'b1;
        e = '0; e.active = 1'b1; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b0, 2'b00, 8'h14, 32'h0, 4'h0);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL active_without_valid: got %h expected %h", o, e); end
    endtask

    task automatic test_write_protected();
        obs_t e, o;
        e = '0; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b01, 8'h10, 32'hFFFF_FFFF, 4'hF);
        #1;
        o = sample(1); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL ro_write_blocked: got %h expected %h", o, e); end

        e = '0; e.active = 1'b1; e.ready = 1'b1; e.bf_valid = 1'b1;
        e.read_data = 32'h9ABC_00F0; e.rmask = 64'h0000_0000_FFFF_00FF; e.value = 64'h0000_0067_89AB_00EF;
        sb.push_back(e);
        drive(1'b1, 2'b00, 8'h10, 32'h0, 4'h0);
        #1;
        o = sample(1); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL ro_read_hit: got %h expected %h", o, e); end
    endtask

    task automatic test_back_to_back();
        obs_t e0, e1, o;
        for (int i = 0; i < 24; i++) begin
            logic [1:0]  acc;
            logic [7:0]  addr;
            logic [31:0] wd;
            logic [3:0]  strb;
            logic        valid;
            acc   = 2'($urandom_range(0, 3));
            addr  = 8'($urandom_range(12, 27));
            wd    = $urandom;
            strb  = 4'($urandom_range(0, 15));
            valid = ($urandom_range(0, 4) != 0);
            match = ($urandom_range(0, 5) != 0);
            bf_rd = {$urandom, $urandom};
            bf_val = {$urandom, $urandom};
            drive(valid, acc, addr, wd, strb);
            e0 = model(1'b1, valid, acc, addr, wd, strb);
            e1 = model(1'b0, valid, acc, addr, wd, strb);
            sb.push_back(e0);
            sb.push_back(e1);
            #1;
            o = sample(0); e0 = sb.pop_front(); tests_run++;
            if (o !== e0) begin failures++; $display("FAIL random_rw_%0d: got %h expected %h", i, o, e0); end
            o = sample(1); e1 = sb.pop_front(); tests_run++;
            if (o !== e1) begin failures++; $display("FAIL random_ro_%0d: got %h expected %h", i, o, e1); end
        end
        match = 1'b1;
    endtask

`ifdef RGGEN_BACKDOOR_EN
    task automatic test_backdoor_priority();
        obs_t e, o;
        @(negedge clk);
        bf_rd = 64'h1234_5678_9ABC_DEF0;
        drive(1'b0, 2'b00, 8'h80, 32'h0, 4'h0);
        bd_valid = 1'b1; bd_rmask = 64'h0; bd_wmask = 64'h0000_0000_0000_FFFF; bd_wdata = 64'h0000_0000_0000_CAFE;
        @(negedge clk);
        bd_valid = 1'b0;
        drive(1'b1, 2'b00, 8'h10, 32'h0, 4'h0);
        sb.push_back(model(1'b1, 1'b1, 2'b00, 8'h10, 32'h0, 4'h0));
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL bd_bus_first: got %h expected %h", o, e); end
        tests_run++;
        if (bd0_ready !== 1'b0) begin failures++; $display("FAIL bd_ready_held: got %b expected 0", bd0_ready); end
        @(negedge clk);
        drive(1'b0, 2'b00, 8'h80, 32'h0, 4'h0);
        e = '0; e.value = bf_val & VB; e.bf_valid = 1'b1;
        e.wmask = 64'h0000_0000_0000_FFFF; e.wdata = 64'h0000_0000_0000_CAFE;
        sb.push_back(e);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e) begin failures++; $display("FAIL bd_applied: got %h expected %h", o, e); end
        tests_run++;
        if (bd0_ready !== 1'b1 || bd0_rdata !== 64'h1234_5678_9ABC_DEF0) begin
            failures++; $display("FAIL bd_ready_data: got %b/%h expected 1/%h", bd0_ready, bd0_rdata, 64'h1234_5678_9ABC_DEF0);
        end
        @(negedge clk);
        e = '0; e.value = bf_val & VB;
        sb.push_back(e);
        #1;
        o = sample(0); e = sb.pop_front(); tests_run++;
        if (o !== e || bd0_ready !== 1'b0) begin failures++; $display("FAIL bd_cleared: got %h/%b expected %h/0", o, bd0_ready, e); end
    endtask

    task automatic test_backdoor_reset();
        obs_t e, o;
        @(negedge clk);
        bd_valid = 1'b1; bd_wmask = 64'hFFFF_0000_0000_0000; bd_wdata = 64'h5555_0000_0000_0000;
        @(negedge clk);
        bd_valid = 1'b0;
        drive(1'b1, 2'b00, 8'h14, 32'h0, 4'h0);
        #1;
        tests_run++;
        if (bd0_ready !== 1'b0) begin failures++; $display("FAIL bd_rst_pre: got %b expected 0", bd0_ready); end
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(1'b0, 2'b00, 8'h80, 32'h0, 4'h0);
            e = '0; e.value = bf_val & VB;
            sb.push_back(e);
            #1;
            o = sample(0); e = sb.pop_front(); tests_run++;
            if (o !== e || bd0_ready !== 1'b0) begin failures++; $display("FAIL bd_rst_dropped_%0d: got %h/%b expected %h/0", i, o, bd0_ready, e); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_miss();
        test_write_protected();
        test_back_to_back();
`ifdef RGGEN_BACKDOOR_EN
        test_backdoor_priority();
        test_backdoor_reset();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, failures);
        $finish;
    end
endmodule
